// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the core's
// instruction-fetch requester and its data (load/store) requester.
// One transaction at a time. Data requests win over fetch, except that a
// streak counter forces a fetch grant after STREAK_MAX consecutive data
// grants issued while fetch was waiting.
module mem_port_arbiter #(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  // fetch requester
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  // data requester
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_data_ok,
  output logic [63:0] d_rdata,
  // memory port
  output logic        m_valid,
  output logic        m_is_write,
  output logic [2:0]  m_size,
  output logic [63:0] m_addr,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_last,
  input  logic [63:0] m_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;

  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic [3:0]  streak_r;
  logic        grant_i_s;
  logic        grant_d_s;
  logic        done_s;

  logic        m_valid_r;
  logic        m_is_write_r;
  logic [2:0]  m_size_r;
  logic [63:0] m_addr_r;
  logic [7:0]  m_strobe_r;
  logic [63:0] m_wdata_r;

  // Arbitration in IDLE: data first unless fetch has waited out a full streak.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (d_valid && !(i_valid && (streak_r == STREAK_LIM))) begin
        grant_d_s = 1'b1;
      end else if (i_valid) begin
        grant_i_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // A transaction finishes on the final beat; beats in IDLE are ignored.
  always_comb begin
    done_s = 1'b0;
    if (state_r != IDLE) begin
      done_s = m_ready && m_last;
    end else begin
      done_s = 1'b0;
    end
  end

  // Next-state selection for the grant/busy FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_next_s = D_BUSY;
        end else if (grant_i_s) begin
          state_next_s = I_BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      I_BUSY, D_BUSY: begin
        if (done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state and the registered memory request; fields are frozen while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      m_valid_r    <= 1'b0;
      m_is_write_r <= 1'b0;
      m_size_r     <= 3'd0;
      m_addr_r     <= 64'd0;
      m_strobe_r   <= 8'd0;
      m_wdata_r    <= 64'd0;
    end else begin
      state_r   <= state_next_s;
      m_valid_r <= (state_next_s == I_BUSY) || (state_next_s == D_BUSY);
      if (grant_d_s) begin
        m_is_write_r <= |d_strobe;
        m_size_r     <= d_size;
        m_addr_r     <= d_addr;
        m_strobe_r   <= d_strobe;
        m_wdata_r    <= d_wdata;
      end else if (grant_i_s) begin
        m_is_write_r <= 1'b0;
        m_size_r     <= 3'b010;
        m_addr_r     <= i_addr;
        m_strobe_r   <= 8'd0;
        m_wdata_r    <= 64'd0;
      end
    end
  end

  // Streak of data grants issued while fetch waits; cleared once fetch is
  // served or is no longer asking.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_r <= 4'd0;
    end else if (state_r == IDLE) begin
      if (!i_valid || grant_i_s) begin
        streak_r <= 4'd0;
      end else if (grant_d_s && (streak_r < STREAK_LIM)) begin
        streak_r <= streak_r + 4'd1;
      end
    end
  end

  // Completion pulses and read data, gated to zero outside the owner's pulse.
  always_comb begin
    i_data_ok = 1'b0;
    d_data_ok = 1'b0;
    i_rdata   = 32'd0;
    d_rdata   = 64'd0;
    if (done_s && (state_r == I_BUSY)) begin
      i_data_ok = 1'b1;
      i_rdata   = m_addr_r[2] ? m_rdata[63:32] : m_rdata[31:0];
    end else if (done_s && (state_r == D_BUSY)) begin
      d_data_ok = 1'b1;
      d_rdata   = m_rdata;
    end else begin
      i_data_ok = 1'b0;
      d_data_ok = 1'b0;
    end
  end

  assign m_valid    = m_valid_r;
  assign m_is_write = m_is_write_r;
  assign m_size     = m_size_r;
  assign m_addr     = m_addr_r;
  assign m_strobe   = m_strobe_r;
  assign m_wdata    = m_wdata_r;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the core's instruction-fetch requester and its data (load/store) requester.
- Sits between the core's ibus/dbus interfaces and the memory port; this is the only path from fetch and MEM stage to memory.
- Grants one transaction at a time and latches the winner's request.
- Data requests have priority over fetch, with an anti-starvation streak limit that forces a fetch grant.

Parameters:
- STREAK_MAX, 4: max consecutive data grants issued while a fetch request is pending. Legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  fetch request valid; held until i_data_ok
- i_addr  in  64  fetch address, 4-byte aligned
- i_data_ok  out  1  fetch complete, one-cycle pulse
- i_rdata  out  32  fetched instruction, valid with i_data_ok
- d_valid  in  1  data request valid; held until d_data_ok
- d_addr  in  64  data address
- d_size  in  3  log2 byte count (0..3)
- d_strobe  in  8  byte write enables; all-zero means read
- d_wdata  in  64  store data
- d_data_ok  out  1  data complete, one-cycle pulse
- d_rdata  out  64  load data, valid with d_data_ok
- m_valid  out  1  memory request valid
- m_is_write  out  1  request is a write
- m_size  out  3  request size
- m_addr  out  64  request address
- m_strobe  out  8  write strobes
- m_wdata  out  64  write data
- m_ready  in  1  memory accepts/returns a beat
- m_last  in  1  final beat of the response
- m_rdata  in  64  memory read data

Behaviour:
- FSM states: IDLE, I_BUSY, D_BUSY. Reset puts the FSM in IDLE and clears every registered output and the streak counter. The m_* outputs reset to 0.
- IDLE arbitration:
  - d_valid only: go to D_BUSY.
  - i_valid only: go to I_BUSY.
  - Both valid: go to D_BUSY unless streak==STREAK_MAX, in which case go to I_BUSY.
  - Neither valid: stay in IDLE.
- Request latch: on the IDLE->BUSY edge, latch the winner's fields into the m_* registers.
  - Fetch: m_is_write=0, m_size=3'b010, m_strobe=0, m_wdata=0.
  - Data: m_is_write=|d_strobe; size, addr, strobe and wdata are copied.
- m_valid is 1 exactly while in I_BUSY or D_BUSY, registered. Latched fields do not change in BUSY, even if the requester changes its inputs.
- Completion: the cycle in BUSY with m_ready&&m_last.
  - The matching data_ok is asserted combinationally in that cycle.
  - FSM returns to IDLE next cycle and m_valid drops.
  - m_ready without m_last keeps the FSM in BUSY (multi-beat tolerated; the last beat's data is returned).
- Read data:
  - d_rdata=m_rdata.
  - i_rdata=m_addr[2] ? m_rdata[63:32] : m_rdata[31:0].
  - Both outputs are 0 when the corresponding data_ok is 0.
- Latency:
  - Request seen in IDLE at cycle N, m_valid at N+1, data_ok at the first cycle ≥N+1 with m_ready&&m_last.
  - A requester holding valid after data_ok is re-arbitrated in the IDLE cycle that follows. Minimum is one dead cycle between back-to-back transactions.
- Streak counter, 4 bits:
  - +1 on each data grant while i_valid=1, saturating at STREAK_MAX.
  - Cleared on any fetch grant, and in any IDLE cycle with i_valid=0.
- The opposite requester's data_ok stays 0 throughout a transaction. i_data_ok and d_data_ok are never high together.
- A requester dropping valid mid-transaction does not abort it: the transaction completes, data_ok pulses and is ignored.
- Reset mid-transaction: next cycle the FSM is in IDLE with m_valid=0 and no data_ok; the in-flight response is discarded.
- m_ready/m_last while in IDLE are ignored.

Test Plan:
- Single fetch: i_valid=1, i_addr=0x8000_0004, memory returns m_rdata=0x1111_2222_3333_4444 with m_ready=m_last=1 one cycle after m_valid -> m_valid at N+1, m_size=2, i_data_ok=1 at N+2 with i_rdata=0x1111_2222.
- Store: d_valid=1, d_addr=0x8000_1000, d_strobe=0x0F, d_wdata=0xDEAD_BEEF, d_size=2 -> m_is_write=1, m_strobe=0x0F, fields stable until d_data_ok; i_data_ok stays 0.
- Contention: i_valid and d_valid both held high continuously, STREAK_MAX=4, each transaction completes immediately -> grant order D,D,D,D,I,D,D,D,D,I; no cycle with both data_ok high.
- Wait states: memory holds m_ready=0 for 5 cycles, then m_ready=1 with m_last=0, then m_ready=m_last=1 -> m_valid high for 7 cycles with constant m_addr; d_data_ok pulses once, on the final cycle.
- Reset mid-transaction: reset asserted at cycle 2 of a D_BUSY transaction -> next cycle m_valid=0, streak=0, no data_ok; a fresh i_valid after reset is granted normally.
- Requester withdraw: d_valid dropped one cycle after grant -> the transaction still completes with exactly one d_data_ok pulse, then the FSM returns to IDLE.
